// File: rtl/cache_set_nway_if.sv
// Request/response, fill and writeback bundle for cache_set_nway.
// master = cache controller / memory side, slave = the cache set.
interface cache_set_nway_if #(
  parameter int TAG_W    = 24,
  parameter int OFFSET_W = 6
) ();
  localparam int BLOCK_BITS = 8 * (2 ** OFFSET_W);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [TAG_W-1:0]      req_tag;
  logic [OFFSET_W-1:0]   req_offset;
  logic [1:0]            req_size;
  logic [63:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [63:0]           resp_rdata;
  logic                  fill_req;
  logic [TAG_W-1:0]      fill_tag;
  logic                  fill_valid;
  logic [BLOCK_BITS-1:0] fill_data;
  logic                  wb_valid;
  logic [TAG_W-1:0]      wb_tag;
  logic [BLOCK_BITS-1:0] wb_data;

  modport master (
    output req_valid, req_write, req_tag, req_offset, req_size, req_wdata,
    output fill_valid, fill_data,
    input  req_ready, resp_valid, resp_hit, resp_rdata,
    input  fill_req, fill_tag, wb_valid, wb_tag, wb_data
  );

  modport slave (
    input  req_valid, req_write, req_tag, req_offset, req_size, req_wdata,
    input  fill_valid, fill_data,
    output req_ready, resp_valid, resp_hit, resp_rdata,
    output fill_req, fill_tag, wb_valid, wb_tag, wb_data
  );
endinterface

// File: rtl/cache_set_nway.sv
// N-way set-associative cache set: true-LRU, write-allocate / write-back.
// Optional CACHE_STATS_EN adds 32-bit hit_count / miss_count outputs.
module cache_set_nway #(
  parameter int WAYS     = 4,
  parameter int TAG_W    = 24,
  parameter int OFFSET_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  cache_set_nway_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);
  localparam int BLOCK_BITS = 8 * (2 ** OFFSET_W);
  localparam int AGE_W      = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WAIT_FILL = 2'd2,
    APPLY     = 2'd3
  } state_t;

  state_t                state_r;
  logic [TAG_W-1:0]      tag_r  [WAYS];
  logic [BLOCK_BITS-1:0] data_r [WAYS];
  logic [AGE_W-1:0]      age_r  [WAYS];
  logic [WAYS-1:0]       valid_r;
  logic [WAYS-1:0]       dirty_r;
  logic                  op_write_r;
  logic [TAG_W-1:0]      op_tag_r;
  logic [OFFSET_W-1:0]   op_off_r;
  logic [1:0]            op_size_r;
  logic [63:0]           op_wdata_r;
  logic [AGE_W-1:0]      victim_r;

  logic                  hit_s;
  logic [AGE_W-1:0]      hit_way_s;
  logic [AGE_W-1:0]      inv_way_s;
  logic [AGE_W-1:0]      lru_way_s;
  logic [AGE_W-1:0]      victim_s;
  logic [AGE_W-1:0]      target_way_s;
  logic [AGE_W-1:0]      old_age_s;
  logic [AGE_W-1:0]      age_next_s [WAYS];
  logic [BLOCK_BITS-1:0] blk_s;
  logic [BLOCK_BITS-1:0] merged_s;
  logic [63:0]           rdata_s;

  // Byte index wraps inside the block; alignment keeps used bytes in range.
  function automatic logic [BLOCK_BITS-1:0] merge_block(
    input logic [BLOCK_BITS-1:0] blk,
    input logic [OFFSET_W-1:0]   off,
    input logic [1:0]            size,
    input logic [63:0]           wdata
  );
    logic [BLOCK_BITS-1:0] res;
    logic [OFFSET_W-1:0]   bidx;
    res = blk;
    for (int i = 0; i < 8; i++) begin
      bidx = off + OFFSET_W'(i);
      res[int'(bidx)*8 +: 8] = (i < int'(4'd1 << size)) ? wdata[i*8 +: 8] : res[int'(bidx)*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [63:0] read_block(
    input logic [BLOCK_BITS-1:0] blk,
    input logic [OFFSET_W-1:0]   off,
    input logic [1:0]            size
  );
    logic [63:0]         res;
    logic [OFFSET_W-1:0] bidx;
    res = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bidx = off + OFFSET_W'(i);
      res[i*8 +: 8] = (i < int'(4'd1 << size)) ? blk[int'(bidx)*8 +: 8] : 8'h00;
    end
    return res;
  endfunction

  // Tag match and victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    inv_way_s = '0;
    lru_way_s = '0;
    for (int j = WAYS - 1; j >= 0; j--) begin
      hit_s     = hit_s | (valid_r[j] & (tag_r[j] == op_tag_r));
      hit_way_s = (valid_r[j] && (tag_r[j] == op_tag_r)) ? AGE_W'(j) : hit_way_s;
      inv_way_s = valid_r[j] ? inv_way_s : AGE_W'(j);
      lru_way_s = (age_r[j] == AGE_W'(WAYS - 1)) ? AGE_W'(j) : lru_way_s;
    end
    victim_s = (&valid_r) ? lru_way_s : inv_way_s;
  end

  // Datapath and LRU update for the way being accessed (hit way or new line).
  always_comb begin
    target_way_s = (state_r == APPLY) ? victim_r : hit_way_s;
    old_age_s    = (state_r == APPLY) ? AGE_W'(WAYS - 1) : age_r[target_way_s];
    blk_s        = data_r[target_way_s];
    merged_s     = merge_block(blk_s, op_off_r, op_size_r, op_wdata_r);
    rdata_s      = read_block(blk_s, op_off_r, op_size_r);
    for (int j = 0; j < WAYS; j++) begin
      if (AGE_W'(j) == target_way_s) begin
        age_next_s[j] = '0;
      end else if (valid_r[j] && (age_r[j] < old_age_s)) begin
        age_next_s[j] = age_r[j] + 1'b1;
      end else begin
        age_next_s[j] = age_r[j];
      end
    end
  end

  // Control FSM, line metadata and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      valid_r        <= '0;
      dirty_r        <= '0;
      for (int j = 0; j < WAYS; j++) age_r[j] <= '0;
      victim_r       <= '0;
      op_write_r     <= 1'b0;
      op_tag_r       <= '0;
      op_off_r       <= '0;
      op_size_r      <= 2'd0;
      op_wdata_r     <= 64'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_rdata <= 64'd0;
      bus.fill_req   <= 1'b0;
      bus.fill_tag   <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_tag     <= '0;
      bus.wb_data    <= '0;
`ifdef CACHE_STATS_EN
      hit_count      <= 32'd0;
      miss_count     <= 32'd0;
`endif
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_rdata <= 64'd0;
      bus.wb_valid   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            op_write_r    <= bus.req_write;
            op_tag_r      <= bus.req_tag;
            op_off_r      <= bus.req_offset & ({OFFSET_W{1'b1}} << bus.req_size);
            op_size_r     <= bus.req_size;
            op_wdata_r    <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            state_r       <= LOOKUP;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            if (op_write_r) dirty_r[hit_way_s] <= 1'b1;
            for (int j = 0; j < WAYS; j++) age_r[j] <= age_next_s[j];
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= 1'b1;
            bus.resp_rdata <= op_write_r ? 64'd0 : rdata_s;
            bus.req_ready  <= 1'b1;
            state_r        <= IDLE;
`ifdef CACHE_STATS_EN
            hit_count      <= hit_count + 32'd1;
`endif
          end else begin
            victim_r     <= victim_s;
            bus.fill_req <= 1'b1;
            bus.fill_tag <= op_tag_r;
            state_r      <= WAIT_FILL;
`ifdef CACHE_STATS_EN
            miss_count   <= miss_count + 32'd1;
`endif
          end
        end
        WAIT_FILL: begin
          if (bus.fill_valid) begin
            if (valid_r[victim_r] && dirty_r[victim_r]) begin
              bus.wb_valid <= 1'b1;
              bus.wb_tag   <= tag_r[victim_r];
              bus.wb_data  <= data_r[victim_r];
            end
            valid_r[victim_r] <= 1'b1;
            dirty_r[victim_r] <= 1'b0;
            bus.fill_req      <= 1'b0;
            state_r           <= APPLY;
          end
        end
        APPLY: begin
          if (op_write_r) dirty_r[victim_r] <= 1'b1;
          for (int j = 0; j < WAYS; j++) age_r[j] <= age_next_s[j];
          bus.resp_valid <= 1'b1;
          bus.resp_hit   <= 1'b0;
          bus.resp_rdata <= op_write_r ? 64'd0 : rdata_s;
          bus.req_ready  <= 1'b1;
          state_r        <= IDLE;
        end
        default: begin
          state_r       <= IDLE;
          bus.req_ready <= 1'b1;
          bus.fill_req  <= 1'b0;
        end
      endcase
    end
  end

  // Line tag and data storage; contents are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state_r)
        LOOKUP: begin
          if (hit_s && op_write_r) data_r[hit_way_s] <= merged_s;
        end
        WAIT_FILL: begin
          if (bus.fill_valid) begin
            tag_r[victim_r]  <= op_tag_r;
            data_r[victim_r] <= bus.fill_data;
          end
        end
        APPLY: begin
          if (op_write_r) data_r[victim_r] <= merged_s;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: doc/cache_set_nway.md
Name: cache_set_nway

Overview:
- Parametrised N-way set-associative cache set; successor to the single-set block used by the cache benches.
- Holds WAYS lines (tag, valid, dirty, 2^OFFSET_W-byte block) with true-LRU replacement and write-allocate / write-back policy.
- Has a one-request-at-a-time request/response handshake and a fill/writeback interface toward the next memory level.
- Sits between the cache controller's index decode and the L2/memory model.

Parameters:
- WAYS, 4: number of ways; power of two, 2..16.
- TAG_W, 24: tag width in bits.
- OFFSET_W, 6: byte-offset width; block is 2^OFFSET_W bytes (BLOCK_BITS = 8 * 2^OFFSET_W).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  set can accept a request (IDLE only).
- req_write  in  1  1 = write, 0 = read.
- req_tag  in  TAG_W  request tag.
- req_offset  in  OFFSET_W  byte offset in block.
- req_size  in  2  access size: 0 = 8 bits, 1 = 16, 2 = 32, 3 = 64.
- req_wdata  in  64  write data; low bytes used per size.
- resp_valid  out  1  one-cycle pulse; response fields valid.
- resp_hit  out  1  1 if the original lookup hit.
- resp_rdata  out  64  read data, zero-extended; 0 for writes.
- fill_req  out  1  level-held request for block fill_tag.
- fill_tag  out  TAG_W  tag being filled.
- fill_valid  in  1  fill data present; consumed only in WAIT_FILL.
- fill_data  in  BLOCK_BITS  fill block, byte 0 at bits [7:0].
- wb_valid  out  1  one-cycle pulse; dirty victim evicted.
- wb_tag  out  TAG_W  evicted tag.
- wb_data  out  BLOCK_BITS  evicted block.

Behaviour:
- Reset: all valid, dirty and LRU ages cleared to 0; state IDLE.
  - Output values: req_ready=1, resp_valid=0, resp_hit=0, resp_rdata=0, fill_req=0, fill_tag=0, wb_valid=0, wb_tag=0, wb_data=0.
  - Reset asserted mid-fill abandons the fill; fill_req drops the next cycle.
- Address alignment: offset aligned by clearing the low req_size bits.
  - Data is little-endian.
  - An access never crosses the block boundary, because alignment guarantees it.
- FSM states: IDLE, LOOKUP, WAIT_FILL, APPLY.
  - IDLE: req_ready=1. When req_valid, the request is latched and the FSM moves to LOOKUP.
  - LOOKUP:
    - On a hit (valid and tag match): the operation is performed, LRU is updated, resp_valid=1 with resp_hit=1, and the FSM returns to IDLE.
    - On a miss: a victim is chosen, fill_req=1 with fill_tag=latched tag, and the FSM moves to WAIT_FILL.
  - WAIT_FILL: fill_req is held until fill_valid.
    - On fill_valid: the block is installed in the victim way (valid=1, dirty=0), fill_req drops, and the FSM moves to APPLY.
    - If the victim was valid and dirty, wb_valid pulses in that same cycle with the old tag and data.
  - APPLY: the latched operation is performed on the installed line, LRU is updated, resp_valid=1 with resp_hit=0, and the FSM returns to IDLE.
- Latency:
  - Hit: request accepted at cycle 0, resp_valid at cycle 1.
  - Miss: fill_req from cycle 1; resp_valid one cycle after the fill_valid cycle.
- Write: merges size bytes at the aligned offset and sets dirty=1.
- Read: returns the bytes zero-extended.
- Victim selection: lowest-index invalid way first. Otherwise the way with age WAYS-1.
- LRU ages:
  - On each access, the accessed way's age becomes 0.
  - Every valid way whose age was less than the accessed way's old age increments by 1.
  - An installed way is treated as old age WAYS-1.
  - Ages stay a permutation over valid ways.
- Boundary conditions:
  - req_valid outside IDLE is ignored (req_ready=0).
  - fill_valid outside WAIT_FILL is ignored.
  - A duplicate tag match in two ways cannot occur, because installs happen only on miss.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count and miss_count, each 32 bits.
  - hit_count increments on every LOOKUP hit; miss_count increments on every LOOKUP miss.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then write tag=16, offset=0, size=0, wdata=3.
  - Miss, fill_req with fill_tag=16; bench supplies fill_data=0.
  - resp_valid 1 cycle after fill_valid, resp_hit=0.
  - Read tag=16, offset=0, size=3 -> hit, resp_rdata=3, latency 1 cycle.
- Write tag=25, offset=8, size=2, wdata=0xDEADBEEF, then read the same address with size=1.
  - resp_rdata=0xBEEF, resp_hit=1 on the read.
- Misaligned access: read offset=3, size=2 -> bytes 0..3 returned (aligned to offset 0).
- WAYS=4: fill tags 1,2,3,4 and dirty tag 1, touch tags 2,3,4, then access tag 5.
  - Victim is tag 1; wb_valid pulses with wb_tag=1 in the fill_valid cycle.
  - A following read of tag 1 misses.
- Assert reset while in WAIT_FILL.
  - Next cycle: fill_req=0, req_ready=1; prior hit tags now miss.
  - A fill_valid pulse after reset is ignored.
- With CACHE_STATS_EN: 3 misses then 5 hits -> miss_count=3, hit_count=5; reset -> both 0.
